// File: rtl/snd_voice_sched.sv
// Fixed-priority, frame-aligned scheduler granting one sound source the 16-bit sample channel.
// Optional SND_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module snd_voice_sched #(
    parameter int NUM_SRC     = 4,
    parameter int DIV         = 256,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   XRST,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [16*NUM_SRC-1:0]  smp_data,
    input  logic [NUM_SRC-1:0]     smp_valid,
    output logic [NUM_SRC-1:0]     src_gnt,
    output logic [NUM_SRC-1:0]     smp_rd,
    output logic [15:0]            soundData,
    output logic                   soundOn,
    output logic                   frame_tick,
    output logic [2:0]             cur_src
`ifdef SND_UNDERRUN_CNT_EN
    ,
    output logic [7:0]             underrun_cnt
`endif
);

    localparam logic [7:0] FRAME_LAST = 8'(DIV - 1);
    localparam int         WW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

    state_t             state, state_n;
    logic [7:0]         frame_cnt;
    logic [WW-1:0]      wait_cnt;
    logic [2:0]         win_idx;
    logic [NUM_SRC-1:0] win_oh;
    logic               win_any;
    logic               sel_valid;
    logic [15:0]        sel_data;
    logic               load_gnt, clr_gnt, capture, underrun;

    // frame_tick is registered so it is high while the counter reads 0
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt == FRAME_LAST);
            frame_cnt  <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 8'd1;
        end
    end

    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        win_any = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_req[i] && !win_any) begin
                win_idx   = 3'(i);
                win_oh[i] = 1'b1;
                win_any   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (3'(i) == cur_src) begin
                sel_valid = smp_valid[i];
                sel_data  = smp_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load_gnt = 1'b0;
        clr_gnt  = 1'b0;
        capture  = 1'b0;
        underrun = 1'b0;
        smp_rd   = '0;
        case (state)
            IDLE: begin
                if (frame_tick && win_any) begin
                    load_gnt = 1'b1;
                    state_n  = FETCH;
                end
            end
            FETCH: begin
                smp_rd  = src_gnt;
                state_n = WAIT;
            end
            WAIT: begin
                // valid wins over a timeout expiring in the same cycle
                if (sel_valid) begin
                    capture = 1'b1;
                    state_n = PLAY;
                end else if (wait_cnt == WAIT_LAST) begin
                    underrun = 1'b1;
                    state_n  = PLAY;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (win_any) begin
                        load_gnt = 1'b1;
                        state_n  = FETCH;
                    end else begin
                        clr_gnt = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            src_gnt   <= '0;
            cur_src   <= '0;
            soundOn   <= 1'b0;
            soundData <= '0;
            wait_cnt  <= '0;
        end else begin
            if (load_gnt) begin
                src_gnt <= win_oh;
                cur_src <= win_idx;
                soundOn <= 1'b1;
            end else if (clr_gnt) begin
                src_gnt <= '0;
                cur_src <= '0;
                soundOn <= 1'b0;
            end
            if (capture)
                soundData <= sel_data;
            else if (underrun || clr_gnt)
                soundData <= '0;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

`ifdef SND_UNDERRUN_CNT_EN
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST)
            underrun_cnt <= '0;
        else if (clr_gnt)
            underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_snd_voice_sched.sv
// Directed bench for snd_voice_sched: per-frame vector table plus reset and frame-timing sequences.
module tb_snd_voice_sched;

    logic        CLK;
    logic        XRST;
    logic [3:0]  src_req;
    logic [63:0] smp_data;
    logic [3:0]  smp_valid;
    logic [3:0]  src_gnt;
    logic [3:0]  smp_rd;
    logic [15:0] soundData;
    logic        soundOn;
    logic        frame_tick;
    logic [2:0]  cur_src;
`ifdef SND_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int tests = 0;
    int failed = 0;
    int unsigned dly = 0;
    int unsigned rd_tot [4];
    int unsigned pend [4];

    snd_voice_sched #(.NUM_SRC(4), .DIV(256), .ACK_TIMEOUT(16)) dut (
        .CLK        (CLK),
        .XRST       (XRST),
        .src_req    (src_req),
        .smp_data   (smp_data),
        .smp_valid  (smp_valid),
        .src_gnt    (src_gnt),
        .smp_rd     (smp_rd),
        .soundData  (soundData),
        .soundOn    (soundOn),
        .frame_tick (frame_tick),
        .cur_src    (cur_src)
`ifdef SND_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        int unsigned dly;
        logic [3:0]  gnt;
        logic [2:0]  cur;
        logic        on;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source model: answers smp_rd with a one-cycle valid after dly cycles (dly 0 = never).
    initial begin
        smp_valid = '0;
        for (int i = 0; i < 4; i++) begin
            rd_tot[i] = 0;
            pend[i]   = 0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                smp_valid[i] = 1'b0;
                if (pend[i] != 0) begin
                    pend[i] = pend[i] - 1;
                    if (pend[i] == 0) smp_valid[i] = 1'b1;
                end
                if (smp_rd[i]) begin
                    rd_tot[i] = rd_tot[i] + 1;
                    if (dly != 0) pend[i] = dly;
                end
            end
        end
    end

    task automatic wait_tick(input string name);
        int k = 0;
        while (!frame_tick && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (!frame_tick) begin
            failed++;
            tests++;
            $display("FAIL %s: no frame_tick within 300 cycles", name);
        end
    endtask

    initial begin
        int first_tick;
        int ticks;
        int badpos;
        int idle_bad;
        int n;
        logic [3:0] prev_gnt;
        logic [3:0] rd_seen;
        int unsigned snap [4];

        vecs[0]  = '{4'b0000, 3,  4'b0000, 3'd0, 1'b0, 16'h0000};
        vecs[1]  = '{4'b0100, 3,  4'b0100, 3'd2, 1'b1, 16'h1234};
        vecs[2]  = '{4'b0101, 3,  4'b0001, 3'd0, 1'b1, 16'hA0A0};
        vecs[3]  = '{4'b0000, 3,  4'b0000, 3'd0, 1'b0, 16'h0000};
        vecs[4]  = '{4'b0110, 3,  4'b0010, 3'd1, 1'b1, 16'hB1B1};
        vecs[5]  = '{4'b1010, 3,  4'b0010, 3'd1, 1'b1, 16'hB1B1};
        vecs[6]  = '{4'b1000, 3,  4'b1000, 3'd3, 1'b1, 16'hC3C3};
        vecs[7]  = '{4'b1000, 17, 4'b1000, 3'd3, 1'b1, 16'h0000};
        vecs[8]  = '{4'b1000, 16, 4'b1000, 3'd3, 1'b1, 16'hC3C3};
        vecs[9]  = '{4'b1000, 0,  4'b1000, 3'd3, 1'b1, 16'h0000};
        vecs[10] = '{4'b0000, 3,  4'b0000, 3'd0, 1'b0, 16'h0000};

        XRST     = 1'b0;
        src_req  = '0;
        smp_data = {16'hC3C3, 16'h1234, 16'hB1B1, 16'hA0A0};
        repeat (3) @(negedge CLK);
        chk("rst gnt",   32'(src_gnt), 32'h0);
        chk("rst on",    32'(soundOn), 32'h0);
        chk("rst data",  32'(soundData), 32'h0);
        chk("rst tick",  32'(frame_tick), 32'h0);
        chk("rst rd",    32'(smp_rd), 32'h0);

        XRST = 1'b1;
        first_tick = 0; ticks = 0; badpos = 0; idle_bad = 0;
        for (n = 1; n <= 1024; n++) begin
            @(negedge CLK);
            if (frame_tick) begin
                ticks++;
                if (first_tick == 0) first_tick = n;
                if (n % 256 != 0) badpos++;
            end
            if (src_gnt != 0 || soundOn || soundData != 0) idle_bad++;
        end
        chk("first tick cycle", 32'(first_tick), 32'd256);
        chk("tick count 1024",  32'(ticks), 32'd4);
        chk("tick misplaced",   32'(badpos), 32'd0);
        chk("idle outputs",     32'(idle_bad), 32'd0);
        @(negedge CLK);

        prev_gnt = 4'b0000;
        for (int r = 0; r < 11; r++) begin
            src_req = vecs[r].req;
            dly     = vecs[r].dly;
            chk($sformatf("row%0d gnt stable mid-frame", r), 32'(src_gnt), 32'(prev_gnt));
            for (int i = 0; i < 4; i++) snap[i] = rd_tot[i];
            wait_tick($sformatf("row%0d tick", r));
            @(negedge CLK);
            chk($sformatf("row%0d gnt", r), 32'(src_gnt), 32'(vecs[r].gnt));
            chk($sformatf("row%0d cur", r), 32'(cur_src), 32'(vecs[r].cur));
            chk($sformatf("row%0d on", r),  32'(soundOn), 32'(vecs[r].on));
            chk($sformatf("row%0d rd", r),  32'(smp_rd), 32'(vecs[r].gnt));
            repeat (39) @(negedge CLK);
            chk($sformatf("row%0d data", r), 32'(soundData), 32'(vecs[r].data));
            for (int i = 0; i < 4; i++) rd_seen[i] = (rd_tot[i] - snap[i] == 1);
            chk($sformatf("row%0d rd pulses", r), 32'(rd_seen), 32'(vecs[r].gnt));
`ifdef SND_UNDERRUN_CNT_EN
            if (r == 9) chk("underrun count", 32'(underrun_cnt), 32'd2);
            if (r == 10) chk("underrun clr idle", 32'(underrun_cnt), 32'd0);
`endif
            prev_gnt = vecs[r].gnt;
        end

        // Play source 2, drop request, then reset asynchronously while waiting for a sample.
        src_req = 4'b0100;
        dly     = 3;
        wait_tick("rst seq tick1");
        repeat (40) @(negedge CLK);
        chk("rst seq play data", 32'(soundData), 32'h1234);
        dly = 0;
        wait_tick("rst seq tick2");
        @(negedge CLK);
        src_req = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("mid-wait gnt held", 32'(src_gnt), 32'h4);
        #2 XRST = 1'b0;
        #1;
        chk("async rst gnt",  32'(src_gnt), 32'h0);
        chk("async rst on",   32'(soundOn), 32'h0);
        chk("async rst data", 32'(soundData), 32'h0);
        chk("async rst cur",  32'(cur_src), 32'h0);
        @(negedge CLK);
        XRST = 1'b1;
        first_tick = 0;
        for (n = 1; n <= 300 && first_tick == 0; n++) begin
            @(negedge CLK);
            if (frame_tick) first_tick = n;
        end
        chk("tick after rst", 32'(first_tick), 32'd256);
        @(negedge CLK);
        chk("idle after rst", 32'(soundOn), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/snd_voice_sched.md
Name: snd_voice_sched

Overview:
- Schedules which sound-effect source (UFO, shot, explosion, march, ...) owns the single 16-bit sample channel feeding the I2S serializer.
- Fixed priority with preemption; source switches happen only at sample-frame boundaries.
- Once per 44.1 kHz frame: fetches one sample from the granted source over a read/valid handshake, holds it on soundData, and drives soundOn.
- Internal frame counter runs from the same CLK/XRST as the serializer, so frame ticks align with the serializer's LRCLK period.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8); index 0 = highest priority
DIV, 256, CLK cycles per sample frame (11.2896 MHz / 256 = 44.1 kHz)
ACK_TIMEOUT, 16, max CLK cycles to wait for smp_valid after smp_rd

Ports:
CLK  in  1  11.2896 MHz system clock
XRST  in  1  asynchronous active-low reset
src_req  in  NUM_SRC  level request per source; high while the effect wants to play
smp_data  in  16*NUM_SRC  flattened sample buses; source i on bits [16i+15:16i]
smp_valid  in  NUM_SRC  per-source sample-valid, sampled only for the granted source
src_gnt  out  NUM_SRC  one-hot grant, all-zero when idle
smp_rd  out  NUM_SRC  one-cycle fetch pulse to the granted source
soundData  out  16  held sample to the serializer
soundOn  out  1  high while a source is granted
frame_tick  out  1  one-cycle pulse at frame boundary
cur_src  out  3  index of granted source, 0 when idle

Behaviour:
- Reset (XRST low, asynchronous):
  - Outputs: src_gnt=0, smp_rd=0, soundData=0, soundOn=0, frame_tick=0, cur_src=0.
  - Internal: frame counter=0, state=IDLE.
- Frame counter:
  - 8-bit, free-running, increments every CLK, wraps at DIV-1 -> 0.
  - frame_tick is registered, high for the one cycle while the counter equals 0.
  - First tick occurs DIV cycles after reset release.
- Arbitration happens only on frame_tick:
  - Winner = lowest index with src_req high.
- FSM states: IDLE, FETCH, WAIT, PLAY.
  - IDLE:
    - On tick with any request: grant winner (src_gnt, cur_src, soundOn=1 take effect the cycle after the tick), go to FETCH.
    - Otherwise stay; soundData=0.
  - FETCH:
    - smp_rd[cur_src]=1 for exactly one cycle, then WAIT.
  - WAIT:
    - If smp_valid[cur_src]: soundData <= smp_data slice for cur_src, next cycle go to PLAY.
    - If ACK_TIMEOUT cycles pass without valid: soundData <= 0 (underrun), go to PLAY.
    - Valid arriving in the same cycle the timeout expires counts as valid.
  - PLAY: hold soundData. On the next tick:
    - Winner exists and differs from cur_src (preemption by higher priority, or current released): switch grant, go to FETCH.
    - Winner equals cur_src: go to FETCH.
    - No request: src_gnt=0, soundOn=0, soundData=0, go to IDLE.
- Grant stability:
  - src_req dropping mid-frame has no effect until the next tick.
  - A lower-priority request never preempts.
  - Simultaneous new requests resolve to the lowest index.
- Tick arriving while in FETCH/WAIT (only possible if ACK_TIMEOUT >= DIV, which is disallowed): ignored.
- soundOn changes only in the cycle after a tick, which keeps the serializer's bit pointer frame-aligned.
- smp_valid from non-granted sources is ignored.
- src_req bits at index >= NUM_SRC do not exist.

Optional Feature:
- Macro: SND_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [7:0].
  - Increments once per WAIT timeout and saturates at 255.
  - Cleared by XRST and whenever the FSM enters IDLE.
- Undefined:
  - Port and counter are absent.
  - Timeout still substitutes sample 0.

Test Plan:
- Reset release, no requests, 1024 cycles -> frame_tick every 256 cycles (first at cycle 256); soundOn=0, soundData=0, src_gnt=0.
- src_req=4'b0100, source 2 returns valid 3 cycles after smp_rd with 16'h1234 -> src_gnt=4'b0100 and soundOn=1 the cycle after the tick; single smp_rd[2] pulse; soundData=16'h1234 held until the next tick.
- Source 2 playing, src_req[0] rises mid-frame -> grant stays 4'b0100 until the next tick, then becomes 4'b0001; fetch goes to source 0.
- src_req=4'b0110 asserted simultaneously from IDLE -> source 1 granted. Source 3 requesting while source 1 plays -> no preemption.
- Granted source never asserts smp_valid -> after 16 cycles soundData=0 and state returns to PLAY; with SND_UNDERRUN_CNT_EN, underrun_cnt increments by 1 per frame and saturates at 255 after 300 frames.
- All requests drop, then XRST asserted mid-WAIT -> after the next tick soundOn=0 and IDLE is entered; on reset every output is 0 immediately (asynchronously) and the frame counter restarts from 0.
